// File: rtl/action_encoder_if.sv
// action_encoder_if
//   Groups the button/enable inputs and the action/control/pending outputs of
//   one player's action encoder.
//   master : drives btn/enable, observes action/control/pending
//   slave  : the encoder itself
//   Signals:
//     btn[5:0]    raw move buttons (kick, punch, sabr, jump, left, right)
//     enable      game running; low freezes rounds
//     action[2:0] issued move code, stable between strobes
//     control     one-cycle strobe marking a valid action
//     pending     a move is latched for the current round
interface action_encoder_if;
  logic [5:0] btn;
  logic       enable;
  logic [2:0] action;
  logic       control;
  logic       pending;

  modport master (output btn, enable, input action, control, pending);
  modport slave  (input btn, enable, output action, control, pending);
endinterface

// File: rtl/action_encoder.sv
// action_encoder
//   Debounces six raw move buttons, latches at most one edge-triggered move
//   per round and, at each round boundary, issues a 3-bit action code with a
//   one-cycle control strobe. Sabr is level-sensitive: held sabr is re-issued
//   every round so the player FSM sees consecutive sabr codes.
//   Optional macro ACTION_REPEAT_EN: every held debounced button is re-issued
//   at the tick when nothing is latched (highest priority wins).
//   Ports:
//     clk    system clock
//     reset  synchronous active-high reset
//     bus    action_encoder_if.slave (btn, enable in; action, control, pending out)
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive differing samples to flip a debounced bit (1..255)
//     ROUND_CYCLES     clock cycles per round (2..65535)
//     IDLE_CODE        code issued when no move is present
module action_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ROUND_CYCLES    = 16,
  parameter logic [2:0]  IDLE_CODE       = 3'b111
) (
  input  logic            clk,
  input  logic            reset,
  action_encoder_if.slave bus
);

  localparam logic [2:0] SABR_CODE = 3'b010;
  // Sabr never produces an edge request; it is sampled as a level at the tick.
  localparam logic [5:0] EDGE_MASK = 6'b111011;

  logic [5:0][7:0] db_cnt_q, db_cnt_d;
  logic [5:0]      deb_q, deb_d;
  logic [15:0]     timer_q;
  logic [2:0]      code_q;
  logic [2:0]      action_q;
  logic            control_q;
  logic            pending_q;

  logic [5:0]      rise;
  logic            tick;
  logic [2:0]      level_code;

  // Lowest set index wins: kick > punch > sabr > jump > left > right.
  function automatic logic [2:0] lowest(input logic [5:0] v);
    lowest = IDLE_CODE;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 6; i++) begin
      if (bus.btn[i] == deb_q[i]) begin
        db_cnt_d[i] = 8'd0;
      end else if (db_cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
        // This sample is the DEBOUNCE_CYCLES-th consecutive differing one.
        deb_d[i]    = bus.btn[i];
        db_cnt_d[i] = 8'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 8'd1;
      end
    end
  end

  // Edge is taken on the debounced next value so a request latches in the
  // same cycle the debounced level changes.
  assign rise = deb_d & ~deb_q & EDGE_MASK;
  assign tick = bus.enable && (timer_q == 16'(ROUND_CYCLES - 1));

`ifdef ACTION_REPEAT_EN
  assign level_code = lowest(deb_q);
`else
  assign level_code = deb_q[2] ? SABR_CODE : IDLE_CODE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q  <= '0;
      deb_q     <= '0;
      timer_q   <= '0;
      code_q    <= IDLE_CODE;
      action_q  <= IDLE_CODE;
      control_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      deb_q     <= deb_d;
      control_q <= 1'b0;
      if (!bus.enable) begin
        timer_q   <= '0;
        pending_q <= 1'b0;
        action_q  <= IDLE_CODE;
      end else if (tick) begin
        timer_q   <= '0;
        control_q <= 1'b1;
        action_q  <= pending_q ? code_q : level_code;
        // A request arriving on the tick belongs to the next round.
        pending_q <= |rise;
        if (|rise) code_q <= lowest(rise);
      end else begin
        timer_q <= timer_q + 16'd1;
        if (!pending_q && |rise) begin
          pending_q <= 1'b1;
          code_q    <= lowest(rise);
        end
      end
    end
  end

  assign bus.action  = action_q;
  assign bus.control = control_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_action_encoder.sv
module tb_action_encoder;
  localparam int D = 4;
  localparam int R = 16;
  localparam logic [2:0] IDLE = 3'b111;

  logic clk = 1'b0;
  logic reset;
  action_encoder_if bus();

  action_encoder #(.DEBOUNCE_CYCLES(D), .ROUND_CYCLES(R), .IDLE_CODE(IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int k = 0;

  // Reference model: debounce judged from the raw sample history, rounds
  // tracked as a cycle age, the latched move held as an int (-1 = none).
  logic [5:0] m_hist[$];
  logic [5:0] m_deb;
  int         m_age;
  int         m_move;
  logic [2:0] m_action;
  logic       m_control;

  function automatic logic [2:0] prio(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return 3'(i);
    return IDLE;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_deb = '0; m_age = 0; m_move = -1; m_action = IDLE; m_control = 1'b0;
  endtask

  task automatic model_step(input logic [5:0] b, input logic e);
    logic [5:0] nd, rise;
    logic [2:0] lvl;
    bit all_diff;
    m_hist.push_back(b);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    nd = m_deb;
    if (m_hist.size() == D) begin
      for (int i = 0; i < 6; i++) begin
        all_diff = 1;
        foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) all_diff = 0;
        if (all_diff) nd[i] = ~m_deb[i];
      end
    end
    rise = nd & ~m_deb & 6'b111011;
`ifdef ACTION_REPEAT_EN
    lvl = prio(m_deb);
`else
    lvl = m_deb[2] ? 3'b010 : IDLE;
`endif
    m_control = 1'b0;
    if (!e) begin
      m_age = 0; m_move = -1; m_action = IDLE;
    end else if (m_age % R == R - 1) begin
      m_control = 1'b1;
      m_action  = (m_move >= 0) ? 3'(m_move) : lvl;
      m_move    = (rise != 0) ? int'(prio(rise)) : -1;
      m_age     = 0;
    end else begin
      m_age++;
      if (m_move < 0 && rise != 0) m_move = int'(prio(rise));
    end
    m_deb = nd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic [5:0] b, input logic e);
    bus.btn = b; bus.enable = e; reset = 1'b0;
    @(posedge clk);
    model_step(b, e);
    #1;
    k++;
    chk("model_action",  32'(bus.action),  32'(m_action));
    chk("model_control", 32'(bus.control), 32'(m_control));
    chk("model_pending", 32'(bus.pending), 32'(m_move >= 0));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; bus.btn = '0; bus.enable = 1'b1;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    chk("reset_action",  32'(bus.action),  32'(IDLE));
    chk("reset_control", 32'(bus.control), 32'd0);
    chk("reset_pending", 32'(bus.pending), 32'd0);
    reset = 1'b0;
    k = 0;
  endtask

  initial begin
    logic [5:0] rb, gl, one;
    int dis;
    one = 6'd1;
    bus.btn = '0; bus.enable = 1'b0; reset = 1'b1;
    do_reset(2);

    // idle strobes
    repeat (15) step(6'd0, 1'b1);
    chk("no_strobe_15", 32'(bus.control), 32'd0);
    step(6'd0, 1'b1);
    chk("strobe_16", 32'(bus.control), 32'd1);
    chk("idle_16", 32'(bus.action), 32'(IDLE));
    repeat (16) step(6'd0, 1'b1);
    chk("strobe_32", 32'(bus.control), 32'd1);

    // 3-cycle glitch on kick
    repeat (3) step(6'b000001, 1'b1);
    step(6'd0, 1'b1);
    chk("glitch_pending", 32'(bus.pending), 32'd0);
    repeat (12) step(6'd0, 1'b1);
    chk("glitch_action", 32'(bus.action), 32'(IDLE));

    // kick and right together
    repeat (3) step(6'b100001, 1'b1);
    chk("simul_pend_early", 32'(bus.pending), 32'd0);
    step(6'b100001, 1'b1);
    chk("simul_pend_rise4", 32'(bus.pending), 32'd1);
    repeat (2) step(6'b100001, 1'b1);
    repeat (10) step(6'd0, 1'b1);
    chk("simul_strobe", 32'(bus.control), 32'd1);
    chk("simul_kick", 32'(bus.action), 32'd0);
    repeat (16) step(6'd0, 1'b1);
    chk("simul_after", 32'(bus.action), 32'(IDLE));

    // sabr held across three ticks
    for (int t = 0; t < 3; t++) begin
      repeat (16) step(6'b000100, 1'b1);
      chk("sabr_strobe", 32'(bus.control), 32'd1);
      chk("sabr_action", 32'(bus.action), 32'd2);
    end
    repeat (16) step(6'd0, 1'b1);
    chk("sabr_release", 32'(bus.action), 32'(IDLE));

    // punch edge exactly on the tick (k=160)
    repeat (12) step(6'd0, 1'b1);
    repeat (4) step(6'b000010, 1'b1);
    chk("tick_edge_strobe", 32'(bus.control), 32'd1);
    chk("tick_edge_prior", 32'(bus.action), 32'(IDLE));
    chk("tick_edge_pending", 32'(bus.pending), 32'd1);
    repeat (10) step(6'b000010, 1'b1);
    repeat (6) step(6'd0, 1'b1);
    chk("tick_edge_next", 32'(bus.action), 32'd1);
    repeat (16) step(6'd0, 1'b1);

    // enable drop with jump pending
    repeat (4) step(6'b001000, 1'b1);
    chk("en_pending", 32'(bus.pending), 32'd1);
    repeat (3) step(6'b001000, 1'b1);
    step(6'd0, 1'b0);
    chk("dis_pending", 32'(bus.pending), 32'd0);
    chk("dis_action", 32'(bus.action), 32'(IDLE));
    repeat (5) step(6'd0, 1'b0);
    repeat (15) step(6'd0, 1'b1);
    chk("reen_no_early", 32'(bus.control), 32'd0);
    step(6'd0, 1'b1);
    chk("reen_strobe", 32'(bus.control), 32'd1);

    // right held over two ticks
    repeat (4) step(6'b100000, 1'b1);
    chk("right_pending", 32'(bus.pending), 32'd1);
    repeat (12) step(6'b100000, 1'b1);
    chk("right_first", 32'(bus.action), 32'd5);
    repeat (16) step(6'b100000, 1'b1);
    chk("right_strobe2", 32'(bus.control), 32'd1);
`ifdef ACTION_REPEAT_EN
    chk("right_second", 32'(bus.action), 32'd5);
`else
    chk("right_second", 32'(bus.action), 32'(IDLE));
`endif

    // randomized traffic against the model
    rb = '0; dis = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
        rb = '0; dis = 0;
      end else begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: rb = '0;
            1, 2: rb = one << $urandom_range(0, 5);
            default: rb = 6'($urandom_range(0, 63));
          endcase
        end
        if (dis > 0) dis--;
        else if ($urandom_range(0, 199) == 0) dis = $urandom_range(1, 20);
        gl = ($urandom_range(0, 24) == 0) ? (one << $urandom_range(0, 5)) : 6'd0;
        step(rb ^ gl, dis == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
